// File: rtl/tblink_rpc_net_pkg.sv
// Shared definitions for the tblink RPC network arbiter.
// Contents:
//   net_state_e      - packet-walk states of the arbiter
//   ADDR_IDX/LEN_IDX - byte offsets of the packet header fields
//   LEN_W            - width of the payload length field / remaining counter
//   beat_state()     - maps a header byte offset to the state that carries it
package tblink_rpc_net_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDR    = 2'd1,
      ST_LEN     = 2'd2,
      ST_PAYLOAD = 2'd3
   } net_state_e;

   localparam int ADDR_IDX = 0;
   localparam int LEN_IDX  = 1;
   localparam int LEN_W    = 8;

   // Header bytes each have a dedicated state; everything past the header is payload.
   function automatic net_state_e beat_state(input int idx);
      case (idx)
         ADDR_IDX: return ST_ADDR;
         LEN_IDX:  return ST_LEN;
         default:  return ST_PAYLOAD;
      endcase
   endfunction

endpackage

// File: rtl/tblink_rpc_rr_pick.sv
// Round-robin winner selection.
// Ports:
//   i_req    - request vector, one bit per port
//   i_last   - index of the most recently served port
//   o_winner - first requesting port found searching upward from i_last+1 with wrap
//   o_any    - at least one request present
module tblink_rpc_rr_pick #(
   parameter  int N_PORTS = 2,
   localparam int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [IDX_W-1:0]   o_winner,
   output logic               o_any
);

   // Each port gets a distance from the slot just after i_last (0 = first in
   // line); the requesting port with the smallest distance wins.
   always_comb begin
      int v_best;
      int v_dist;
      o_winner = '0;
      o_any    = 1'b0;
      v_best   = N_PORTS;
      v_dist   = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         v_dist = (k + N_PORTS - 1 - int'(i_last)) % N_PORTS;
         if (i_req[k] && (v_dist < v_best)) begin
            v_best   = v_dist;
            o_winner = IDX_W'(k);
            o_any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tblink_rpc_net_arb.sv
// Packet-granular round-robin arbiter merging N_PORTS requester byte streams
// into one stream toward tblink_rpc_ctrl. A grant covers a whole packet
// (address byte, length byte L, L payload bytes) and is never changed mid-packet.
// Ports:
//   clock, reset      - single clock, synchronous active-high reset
//   t_dat/t_valid     - requester streams (port k data at [k*WIDTH +: WIDTH])
//   t_ready           - per-port ready; only the granted port sees i_ready
//   i_dat/i_valid     - merged stream out
//   i_ready           - merged stream ready in
//   busy              - a packet is granted
//   gnt_id            - granted port index, meaningful while busy
module tblink_rpc_net_arb
   import tblink_rpc_net_pkg::*;
#(
   parameter  int N_PORTS = 2,
   parameter  int WIDTH   = 8,
   localparam int IDX_W   = $clog2(N_PORTS)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_PORTS*WIDTH-1:0]   t_dat,
   input  logic [N_PORTS-1:0]         t_valid,
   output logic [N_PORTS-1:0]         t_ready,
   output logic [WIDTH-1:0]           i_dat,
   output logic                       i_valid,
   input  logic                       i_ready,
   output logic                       busy,
   output logic [IDX_W-1:0]           gnt_id
);

   net_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_gnt, w_gnt_nxt;
   logic [IDX_W-1:0] r_last, w_last_nxt;
   logic [LEN_W-1:0] r_rem, w_rem_nxt;
   logic [IDX_W-1:0] w_pick;
   logic             w_any;
   logic             w_busy;
   logic             w_vld;
   logic             w_xfer;
   logic [WIDTH-1:0] w_dat;
   logic [LEN_W-1:0] w_len;

   tblink_rpc_rr_pick #(
      .N_PORTS (N_PORTS)
   ) u_pick (
      .i_req    (t_valid),
      .i_last   (r_last),
      .o_winner (w_pick),
      .o_any    (w_any)
   );

   assign w_busy = (r_state != ST_IDLE);

   // Granted-port mux; ready is steered only while a packet is in flight so
   // nothing transfers during the arbitration cycle.
   always_comb begin
      w_dat   = '0;
      w_vld   = 1'b0;
      t_ready = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (r_gnt == IDX_W'(k)) begin
            w_dat      = t_dat[k*WIDTH +: WIDTH];
            w_vld      = t_valid[k];
            t_ready[k] = w_busy & i_ready;
         end
      end
   end

   assign i_dat   = w_dat;
   assign i_valid = w_busy & w_vld;
   assign w_xfer  = i_valid & i_ready;
   assign w_len   = LEN_W'(w_dat);
   assign busy    = w_busy;
   assign gnt_id  = r_gnt;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      w_rem_nxt   = r_rem;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = beat_state(ADDR_IDX);
            end
         end
         ST_ADDR: begin
            if (w_xfer) w_state_nxt = beat_state(LEN_IDX);
         end
         ST_LEN: begin
            if (w_xfer) begin
               w_rem_nxt = w_len;
               if (w_len == '0) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = r_gnt;
               end else begin
                  w_state_nxt = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_xfer) begin
               w_rem_nxt = r_rem - LEN_W'(1);
               if (r_rem == LEN_W'(1)) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = r_gnt;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // last_gnt resets to the top port so port 0 is first in line.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_last  <= IDX_W'(N_PORTS - 1);
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

endmodule

// File: tb/tb_tblink_rpc_net_arb.sv
module tb_tblink_rpc_net_arb;

   localparam int NP = 3;
   localparam int W  = 8;
   localparam int IW = $clog2(NP);

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NP*W-1:0] t_dat = '0;
   logic [NP-1:0]   t_valid = '0;
   logic [NP-1:0]   t_ready;
   logic [W-1:0]    i_dat;
   logic            i_valid;
   logic            i_ready = 1'b1;
   logic            busy;
   logic [IW-1:0]   gnt_id;

   tblink_rpc_net_arb #(.N_PORTS(NP), .WIDTH(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .t_dat   (t_dat),
      .t_valid (t_valid),
      .t_ready (t_ready),
      .i_dat   (i_dat),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .busy    (busy),
      .gnt_id  (gnt_id)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: per-port byte queues holding whole packets, plus the
   // packet currently owning the merged stream and how many of its beats remain.
   logic [7:0] q [NP][$];
   int m_owner = -1;
   int m_last  = NP - 1;
   int m_left  = 0;
   int grant_log[$];
   int busy_cnt = 0;

   bit rand_valid = 1'b0;
   int valid_pct  = 100;
   int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_pkt(input int p, input int addr, input int len);
      q[p].push_back(8'(addr));
      q[p].push_back(8'(len));
      for (int i = 0; i < len; i++) q[p].push_back(8'($urandom));
   endtask

   // One clock: drive inputs on the falling edge, compare outputs against the
   // model, then advance the model with the values the DUT will sample.
   task automatic step();
      logic [NP-1:0] exp_ready;
      logic          exp_valid;
      @(negedge clock);
      for (int k = 0; k < NP; k++) begin
         if (q[k].size() > 0 && (!rand_valid || $urandom_range(99) < valid_pct)) begin
            t_valid[k]       = 1'b1;
            t_dat[k*W +: W]  = q[k][0];
         end else begin
            t_valid[k]       = 1'b0;
            t_dat[k*W +: W]  = 8'($urandom);
         end
      end
      case (ready_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = ~i_ready;
         default: i_ready = 1'($urandom_range(1));
      endcase
      #1;
      exp_ready = '0;
      exp_valid = 1'b0;
      if (m_owner >= 0) begin
         exp_valid = t_valid[m_owner];
         if (i_ready) exp_ready[m_owner] = 1'b1;
      end
      if (busy === 1'b1) busy_cnt++;
      chk("busy", busy, (m_owner >= 0));
      chk("t_ready", t_ready, exp_ready);
      chk("i_valid", i_valid, exp_valid);
      if (m_owner >= 0) chk("gnt_id", gnt_id, m_owner);
      if (exp_valid) chk("i_dat", i_dat, q[m_owner][0]);

      if (m_owner < 0) begin
         for (int i = 1; i <= NP; i++) begin
            int p;
            p = (m_last + i) % NP;
            if (t_valid[p]) begin
               m_owner = p;
               m_left  = 2 + int'(q[p][1]);
               grant_log.push_back(p);
               break;
            end
         end
      end else if (t_valid[m_owner] && i_ready) begin
         void'(q[m_owner].pop_front());
         m_left--;
         if (m_left == 0) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end
   endtask

   function automatic bit pending();
      bit r;
      r = (m_owner >= 0);
      for (int k = 0; k < NP; k++) if (q[k].size() > 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(input int max_cyc);
      int c;
      c = 0;
      while (pending() && c < max_cyc) begin
         step();
         c++;
      end
      chk("drain_in_time", (c < max_cyc), 1);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clock);
      reset = 1'b1;
      repeat (cycles) begin
         @(posedge clock);
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_i_valid", i_valid, 0);
         chk("rst_t_ready", t_ready, 0);
         chk("rst_gnt_id", gnt_id, 0);
      end
      @(negedge clock);
      reset   = 1'b0;
      t_valid = '0;
      for (int k = 0; k < NP; k++) q[k].delete();
      m_owner = -1;
      m_last  = NP - 1;
      m_left  = 0;
   endtask

   initial begin
      int c;
      do_reset(2);

      // Single port-0 packet, always ready.
      grant_log.delete();
      busy_cnt = 0;
      q[0].push_back(8'h01); q[0].push_back(8'h02);
      q[0].push_back(8'hAA); q[0].push_back(8'hBB);
      drain(50);
      step();
      chk("single_busy_cycles", busy_cnt, 4);
      chk("single_log_len", grant_log.size(), 1);
      if (grant_log.size() >= 1) chk("single_port", grant_log[0], 0);

      // Ports 0 and 1 both valid out of reset.
      do_reset(1);
      grant_log.delete();
      push_pkt(0, 8'h10, 1);
      push_pkt(1, 8'h20, 1);
      drain(50);
      chk("both_log_len", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         chk("both_first", grant_log[0], 0);
         chk("both_second", grant_log[1], 1);
      end

      // Zero-length packet followed by another grant.
      grant_log.delete();
      busy_cnt = 0;
      q[0].push_back(8'h03); q[0].push_back(8'h00);
      push_pkt(1, 8'h04, 1);
      drain(50);
      chk("zero_len_busy_cycles", busy_cnt, 5);
      chk("zero_len_log_len", grant_log.size(), 2);

      // Port 1 mid-packet with stalling downstream while port 0 requests.
      grant_log.delete();
      ready_mode = 1;
      push_pkt(1, 8'h30, 4);
      step();
      push_pkt(0, 8'h31, 2);
      drain(100);
      ready_mode = 0;
      chk("stall_log_len", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         chk("stall_first", grant_log[0], 1);
         chk("stall_second", grant_log[1], 0);
      end

      // Port 0 three packets against a continuously requesting port 1.
      do_reset(1);
      grant_log.delete();
      for (int i = 0; i < 3; i++) begin
         push_pkt(0, 8'h40 + i, 1 + i);
         push_pkt(1, 8'h50 + i, 2);
      end
      drain(200);
      chk("alt_log_len", grant_log.size(), 6);
      if (grant_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) chk("alt_order", grant_log[i], i % 2);
      end

      // Reset in the middle of a payload with 5 bytes outstanding.
      push_pkt(1, 8'h60, 8);
      c = 0;
      while (!(m_owner == 1 && m_left == 5) && c < 50) begin
         step();
         c++;
      end
      chk("reach_rem5", (c < 50), 1);
      do_reset(1);
      grant_log.delete();
      push_pkt(1, 8'h70, 1);
      push_pkt(0, 8'h71, 1);
      drain(50);
      chk("post_rst_log_len", grant_log.size(), 2);
      if (grant_log.size() >= 1) chk("post_rst_first", grant_log[0], 0);

      // Randomised traffic: sporadic valids, random ready, random lengths.
      rand_valid = 1'b1;
      ready_mode = 2;
      for (int r = 0; r < 6; r++) begin
         valid_pct = $urandom_range(100, 40);
         for (int k = 0; k < NP; k++) begin
            int np;
            np = $urandom_range(3);
            for (int j = 0; j < np; j++) push_pkt(k, $urandom_range(255), $urandom_range(6));
         end
         drain(3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
